// File: rtl/shift_register_param_framed.sv
// ---------------------------------------------------------------------------
// shift_register_param_framed
//
// Bidirectional serial-capture shift register for the ADC / hydrophone front
// end. Bits shift in on enabled edges in either direction, the register can
// be parallel-loaded and drained through serial_out, and a bit counter
// raises a one-cycle word_done pulse on every completed WIDTH-bit word.
//
// Optional feature (compile-time macro SHIFT_REG_CAPTURE_EN):
//   adds capture_q / capture_valid, a holding register for the last completed
//   word so the next word can shift in without disturbing it.
//
// Ports
//   clk           in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   enable        in   shift strobe, one bit per enabled edge
//   load          in   parallel load strobe, priority over enable
//   dir           in   0: d enters q[0], word moves to MSB
//                      1: d enters q[WIDTH-1], word moves to LSB
//   d             in   serial data in
//   load_data     in   parallel load value
//   q             out  register contents
//   serial_out    out  bit leaving the register (q[WIDTH-1] or q[0] by dir)
//   bit_count     out  enabled shifts since last word boundary or load
//   word_done     out  one-cycle pulse, high with the completed word on q
//   capture_q     out  last completed word        (SHIFT_REG_CAPTURE_EN)
//   capture_valid out  a word has been captured   (SHIFT_REG_CAPTURE_EN)
// ---------------------------------------------------------------------------
module shift_register_param_framed #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CNT_W       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             load,
  input  logic             dir,
  input  logic             d,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic [CNT_W-1:0] bit_count,
  output logic             word_done
`ifdef SHIFT_REG_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] capture_q,
  output logic             capture_valid
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
`ifdef SHIFT_REG_CAPTURE_EN
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             capv_q, capv_d;
`endif

  // Next-state logic. Priority: load > enable > hold.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    data_d = data_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
`ifdef SHIFT_REG_CAPTURE_EN
    cap_d  = cap_q;
    capv_d = capv_q;
`endif
    if (load) begin
      data_d = load_data;
      cnt_d  = '0;
    end else if (enable) begin
      if (dir) data_d = {d, data_q[WIDTH-1:1]};
      else     data_d = {data_q[WIDTH-2:0], d};

      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
`ifdef SHIFT_REG_CAPTURE_EN
        // Capture the completed word itself, i.e. the post-shift value.
        cap_d  = data_d;
        capv_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= RESET_VALUE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef SHIFT_REG_CAPTURE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_q  <= '0;
      capv_q <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      capv_q <= capv_d;
    end
  end

  assign capture_q     = cap_q;
  assign capture_valid = capv_q;
`endif

  assign q          = data_q;
  assign bit_count  = cnt_q;
  assign word_done  = done_q;
  assign serial_out = dir ? data_q[0] : data_q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_param_framed.sv
// ---------------------------------------------------------------------------
// tb_shift_register_param_framed
//
// Self-checking bench for shift_register_param_framed (WIDTH=16, non-zero
// RESET_VALUE). A word-level reference model (integer shift arithmetic and a
// modulo-WIDTH bit count) tracks the expected outputs; every clock edge all
// outputs are compared #1 after the rising edge. Directed scenarios cover
// reset, MSB-first capture, gapped enable, load/serial drain, load during
// shifting, mid-word reset and (with SHIFT_REG_CAPTURE_EN) word capture,
// followed by a randomized mixed-traffic run.
// ---------------------------------------------------------------------------
module tb_shift_register_param_framed;

  localparam int          W  = 16;
  localparam logic [15:0] RV = 16'h5A3C;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable, load, dir, d;
  logic [W-1:0]  load_data;
  logic [W-1:0]  q;
  logic          serial_out;
  logic [3:0]    bit_count;
  logic          word_done;
`ifdef SHIFT_REG_CAPTURE_EN
  logic [W-1:0]  capture_q;
  logic          capture_valid;
`endif

  shift_register_param_framed #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .load       (load),
    .dir        (dir),
    .d          (d),
    .load_data  (load_data),
    .q          (q),
    .serial_out (serial_out),
    .bit_count  (bit_count),
    .word_done  (word_done)
`ifdef SHIFT_REG_CAPTURE_EN
    ,
    .capture_q     (capture_q),
    .capture_valid (capture_valid)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [W-1:0] m_q;
  int           m_cnt;
  logic         m_done;
  logic [W-1:0] m_cap;
  logic         m_capv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q    = RV;
    m_cnt  = 0;
    m_done = 1'b0;
    m_cap  = '0;
    m_capv = 1'b0;
  endtask

  // Word-level behaviour for one rising edge, using the inputs as applied.
  task automatic model_edge();
    if (load) begin
      m_q    = load_data;
      m_cnt  = 0;
      m_done = 1'b0;
    end else if (enable) begin
      if (dir) m_q = (m_q >> 1) | (16'(d) << (W - 1));
      else     m_q = (m_q << 1) | 16'(d);
      m_cnt  = (m_cnt + 1) % W;
      m_done = (m_cnt == 0);
      if (m_done) begin
        m_cap  = m_q;
        m_capv = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".q"},          32'(q),          32'(m_q));
    check({tag, ".bit_count"},  32'(bit_count),  32'(m_cnt));
    check({tag, ".word_done"},  32'(word_done),  32'(m_done));
    check({tag, ".serial_out"}, 32'(serial_out), 32'(dir ? m_q[0] : m_q[W-1]));
`ifdef SHIFT_REG_CAPTURE_EN
    check({tag, ".capture_q"},     32'(capture_q),     32'(m_cap));
    check({tag, ".capture_valid"}, 32'(capture_valid), 32'(m_capv));
`endif
  endtask

  task automatic drive(input logic l, input logic e, input logic dr, input logic dd,
                       input logic [W-1:0] ld);
    load      = l;
    enable    = e;
    dir       = dr;
    d         = dd;
    load_data = ld;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Shift a word in MSB first with dir=0.
  task automatic shift_word(input string tag, input logic [W-1:0] word);
    for (int i = W - 1; i >= 0; i--) begin
      drive(1'b0, 1'b1, 1'b0, word[i], '0);
      tick(tag);
    end
  endtask

  initial begin
    logic [W-1:0] word;
    logic         exp_so;

    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    resetn = 1'b1;

    // 1: asynchronous reset with no clock edge.
    #2 resetn = 1'b0;
    #1;
    model_reset();
    compare_all("t1_reset");
    @(negedge clk);
    resetn = 1'b1;

    // 2: MSB-first word, continuous enable.
    word = 16'hA5C3;
    shift_word("t2_shift", word);
    check("t2_final_q",    32'(q),         32'h0000A5C3);
    check("t2_final_done", 32'(word_done), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick("t2_idle");
    check("t2_done_once", 32'(word_done), 32'd0);

    // 3: same word with random enable gaps; q must hold through the gaps.
    for (int i = W - 1; i >= 0; i--) begin
      int gap;
      gap = $urandom_range(1, 5);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 1'b0, 1'(($urandom) & 1), 1'($urandom & 1), 16'($urandom));
        dir = 1'b0;
        tick("t3_gap");
      end
      drive(1'b0, 1'b1, 1'b0, word[i], '0);
      tick("t3_shift");
    end
    check("t3_final_q",    32'(q),         32'h0000A5C3);
    check("t3_final_done", 32'(word_done), 32'd1);

    // 4: parallel load then drain LSB-first through serial_out.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h8001);
    tick("t4_load");
    check("t4_so_first", 32'(serial_out), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
      tick("t4_drain");
      exp_so = (i == 15);
      check($sformatf("t4_so_%0d", i), 32'(serial_out), 32'(exp_so));
    end
    check("t4_final_q", 32'(q), 32'h00000001);

    // 5: load wins over enable at bit_count=7, then a full word completes.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick("t5_clear");
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 1'($urandom & 1), 1'($urandom & 1), '0);
      tick("t5_pre");
    end
    check("t5_cnt7", 32'(bit_count), 32'd7);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
    tick("t5_load");
    check("t5_load_q",    32'(q),         32'h00001234);
    check("t5_load_cnt",  32'(bit_count), 32'd0);
    check("t5_load_done", 32'(word_done), 32'd0);
    for (int i = 1; i <= W; i++) begin
      drive(1'b0, 1'b1, 1'($urandom & 1), 1'($urandom & 1), '0);
      tick("t5_word");
      check($sformatf("t5_done_%0d", i), 32'(word_done), 32'(i == W));
    end

    // 6: mid-word reset, then capture behaviour.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick("t6_idle");
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'($urandom & 1), '0);
      tick("t6_pre");
    end
    check("t6_cnt9", 32'(bit_count), 32'd9);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    compare_all("t6_reset");
    @(negedge clk);
    resetn = 1'b1;
    word = 16'h0F0F;
    shift_word("t6_word", word);
    check("t6_word_q",    32'(q),         32'h00000F0F);
    check("t6_word_done", 32'(word_done), 32'd1);
`ifdef SHIFT_REG_CAPTURE_EN
    check("t6_cap_q",     32'(capture_q),     32'h00000F0F);
    check("t6_cap_valid", 32'(capture_valid), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'($urandom & 1), '0);
      tick("t6_next");
    end
`ifdef SHIFT_REG_CAPTURE_EN
    check("t6_cap_hold", 32'(capture_q), 32'h00000F0F);
`endif

    // 7: randomized mixed traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom & 1), 1'($urandom & 1), 16'($urandom));
      tick("t7_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
